// File: rtl/wb_stage.sv
// Writeback stage: selects ALU/load/link data and registers the GPR write port (1-cycle latency).
// stall holds all registers; flush inserts a bubble. WB_SUBWORD_LOAD_EN enables lb/lbu/lh/lhu extraction.
module wb_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic        m_valid,
    input  logic [31:0] m_pc,
    input  logic        m_reg_we,
    input  logic [4:0]  m_a3,
    input  logic [1:0]  m_wb_sel,
    input  logic [2:0]  m_ld_type,
    input  logic [31:0] m_alu,
    input  logic [31:0] m_dm_rd,
    output logic        w_we,
    output logic [4:0]  w_a3,
    output logic [31:0] w_wd,
    output logic [31:0] w_pc,
    output logic        w_valid
);

    localparam logic [31:0] RESET_PC = 32'h0000_3000;

    localparam logic [1:0] SEL_ALU  = 2'd0;
    localparam logic [1:0] SEL_MEM  = 2'd1;
    localparam logic [1:0] SEL_LINK = 2'd2;

    logic [31:0] ld_data;
    logic [31:0] sel_data;
    logic        we_next;

`ifdef WB_SUBWORD_LOAD_EN
    localparam logic [2:0] LD_LB  = 3'd1;
    localparam logic [2:0] LD_LBU = 3'd2;
    localparam logic [2:0] LD_LH  = 3'd3;
    localparam logic [2:0] LD_LHU = 3'd4;

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    always_comb begin
        ld_byte = m_dm_rd[7:0];
        case (m_alu[1:0])
            2'd0: ld_byte = m_dm_rd[7:0];
            2'd1: ld_byte = m_dm_rd[15:8];
            2'd2: ld_byte = m_dm_rd[23:16];
            2'd3: ld_byte = m_dm_rd[31:24];
            default: ld_byte = m_dm_rd[7:0];
        endcase
        // Halfword loads ignore address bit 0.
        ld_half = m_alu[1] ? m_dm_rd[31:16] : m_dm_rd[15:0];

        ld_data = m_dm_rd;
        case (m_ld_type)
            LD_LB:   ld_data = {{24{ld_byte[7]}}, ld_byte};
            LD_LBU:  ld_data = {24'h0, ld_byte};
            LD_LH:   ld_data = {{16{ld_half[15]}}, ld_half};
            LD_LHU:  ld_data = {16'h0, ld_half};
            default: ld_data = m_dm_rd;
        endcase
    end
`else
    logic unused_ld;
    assign unused_ld = ^m_ld_type;
    assign ld_data   = m_dm_rd;
`endif

    always_comb begin
        sel_data = 32'h0;
        case (m_wb_sel)
            SEL_ALU:  sel_data = m_alu;
            SEL_MEM:  sel_data = ld_data;
            SEL_LINK: sel_data = m_pc + 32'd8;
            default:  sel_data = 32'h0;
        endcase
    end

    assign we_next = m_valid && m_reg_we && (m_a3 != 5'd0);

    always_ff @(posedge clk) begin
        if (reset) begin
            w_valid <= 1'b0;
            w_we    <= 1'b0;
            w_a3    <= 5'd0;
            w_wd    <= 32'h0;
            w_pc    <= RESET_PC;
        end else if (flush || (!stall && !m_valid)) begin
            w_valid <= 1'b0;
            w_we    <= 1'b0;
            w_a3    <= 5'd0;
            w_wd    <= 32'h0;
            w_pc    <= m_pc;
        end else if (!stall) begin
            w_valid <= 1'b1;
            w_we    <= we_next;
            w_a3    <= m_a3;
            w_wd    <= sel_data;
            w_pc    <= m_pc;
        end
    end

endmodule

// File: tb/tb_wb_stage.sv
// Scoreboard bench for wb_stage: a reference model predicts each cycle's registered outputs.
module tb_wb_stage;

    logic        clk = 1'b0;
    logic        reset, stall, flush;
    logic        m_valid, m_reg_we;
    logic [31:0] m_pc, m_alu, m_dm_rd;
    logic [4:0]  m_a3;
    logic [1:0]  m_wb_sel;
    logic [2:0]  m_ld_type;
    logic        w_we, w_valid;
    logic [4:0]  w_a3;
    logic [31:0] w_wd, w_pc;

    always #5 clk = ~clk;

    wb_stage dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .m_valid(m_valid), .m_pc(m_pc), .m_reg_we(m_reg_we), .m_a3(m_a3),
        .m_wb_sel(m_wb_sel), .m_ld_type(m_ld_type), .m_alu(m_alu), .m_dm_rd(m_dm_rd),
        .w_we(w_we), .w_a3(w_a3), .w_wd(w_wd), .w_pc(w_pc), .w_valid(w_valid)
    );

    typedef struct packed {
        logic        valid;
        logic        we;
        logic [4:0]  a3;
        logic [31:0] wd;
        logic [31:0] pc;
    } wb_t;

    wb_t model;
    wb_t exp_q[$];
    int  errors = 0;
    int  checks = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] load_ref(input logic [2:0] t, input logic [31:0] a,
                                             input logic [31:0] rd);
`ifdef WB_SUBWORD_LOAD_EN
        logic [31:0] b, h;
        b = rd >> (8 * a[1:0]);
        h = rd >> (16 * a[1]);
        case (t)
            3'd1:    return {{24{b[7]}}, b[7:0]};
            3'd2:    return {24'h0, b[7:0]};
            3'd3:    return {{16{h[15]}}, h[15:0]};
            3'd4:    return {16'h0, h[15:0]};
            default: return rd;
        endcase
`else
        return (t == 3'd7) ? rd : rd;
`endif
    endfunction

    function automatic wb_t predict(input wb_t cur);
        wb_t n;
        n = cur;
        if (reset) begin
            n = '{valid: 1'b0, we: 1'b0, a3: 5'd0, wd: 32'h0, pc: 32'h0000_3000};
        end else if (flush || (!stall && !m_valid)) begin
            n = '{valid: 1'b0, we: 1'b0, a3: 5'd0, wd: 32'h0, pc: m_pc};
        end else if (!stall) begin
            n.valid = 1'b1;
            n.we    = m_reg_we && (m_a3 != 5'd0);
            n.a3    = m_a3;
            n.pc    = m_pc;
            case (m_wb_sel)
                2'd0:    n.wd = m_alu;
                2'd1:    n.wd = load_ref(m_ld_type, m_alu, m_dm_rd);
                2'd2:    n.wd = m_pc + 32'd8;
                default: n.wd = 32'h0;
            endcase
        end
        return n;
    endfunction

    // Inputs must already be driven; predicts, clocks, and compares the popped entry.
    task automatic cycle(input string tag);
        wb_t e;
        model = predict(model);
        exp_q.push_back(model);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check_eq({tag, ".valid"}, {31'h0, w_valid}, {31'h0, e.valid});
        check_eq({tag, ".we"},    {31'h0, w_we},    {31'h0, e.we});
        check_eq({tag, ".a3"},    {27'h0, w_a3},    {27'h0, e.a3});
        check_eq({tag, ".wd"},    w_wd,             e.wd);
        check_eq({tag, ".pc"},    w_pc,             e.pc);
    endtask

    task automatic set_instr(input logic v, input logic we, input logic [4:0] a3,
                             input logic [1:0] sel, input logic [2:0] ld,
                             input logic [31:0] pc, input logic [31:0] alu,
                             input logic [31:0] rd);
        m_valid = v; m_reg_we = we; m_a3 = a3; m_wb_sel = sel;
        m_ld_type = ld; m_pc = pc; m_alu = alu; m_dm_rd = rd;
    endtask

    task automatic randomize_instr();
        set_instr($urandom_range(0, 3) != 0, 1'($urandom), 5'($urandom), 2'($urandom),
                  3'($urandom), $urandom, $urandom, $urandom);
    endtask

    initial begin
        model = '0;
        reset = 1'b1; stall = 1'b0; flush = 1'b0;
        set_instr(1'b1, 1'b1, 5'd7, 2'd0, 3'd0, 32'h100, 32'hDEAD_BEEF, 32'h0);
        @(posedge clk); #1;
        model = '{valid: 1'b0, we: 1'b0, a3: 5'd0, wd: 32'h0, pc: 32'h0000_3000};
        cycle("reset");
        check_eq("reset_pc", w_pc, 32'h0000_3000);
        check_eq("reset_wd", w_wd, 32'h0);
        reset = 1'b0;

        set_instr(1'b1, 1'b1, 5'd5, 2'd1, 3'd1, 32'h200, 32'h2, 32'h1280_FF34);
        cycle("lb");
        check_eq("lb_we", {31'h0, w_we}, 32'h1);
`ifdef WB_SUBWORD_LOAD_EN
        check_eq("lb_wd", w_wd, 32'hFFFF_FF80);
        set_instr(1'b1, 1'b1, 5'd5, 2'd1, 3'd4, 32'h204, 32'h2, 32'h1280_FF34);
        cycle("lhu");
        check_eq("lhu_wd", w_wd, 32'h0000_1280);
        set_instr(1'b1, 1'b1, 5'd6, 2'd1, 3'd3, 32'h208, 32'h1, 32'h1280_FF34);
        cycle("lh_lo");
        check_eq("lh_lo_wd", w_wd, 32'hFFFF_FF34);
`else
        check_eq("ld_raw_wd", w_wd, 32'h1280_FF34);
`endif

        set_instr(1'b1, 1'b1, 5'd31, 2'd2, 3'd0, 32'hFFFF_FFFC, 32'h0, 32'h0);
        cycle("link");
        check_eq("link_wd", w_wd, 32'h0000_0004);
        check_eq("link_a3", {27'h0, w_a3}, 32'd31);

        set_instr(1'b1, 1'b1, 5'd0, 2'd0, 3'd0, 32'h300, 32'h1234, 32'h0);
        cycle("r0");
        check_eq("r0_we", {31'h0, w_we}, 32'h0);

        set_instr(1'b1, 1'b1, 5'd9, 2'd3, 3'd0, 32'h304, 32'hFFFF, 32'hFFFF);
        cycle("rsvd");

        set_instr(1'b0, 1'b1, 5'd9, 2'd0, 3'd0, 32'h308, 32'h55, 32'h0);
        cycle("invalid");

        set_instr(1'b1, 1'b1, 5'd12, 2'd0, 3'd0, 32'h400, 32'hCAFE_0001, 32'h0);
        cycle("pre_stall");
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            randomize_instr();
            cycle("stall");
            check_eq("stall_wd", w_wd, 32'hCAFE_0001);
        end
        flush = 1'b1;
        set_instr(1'b1, 1'b1, 5'd3, 2'd0, 3'd0, 32'h500, 32'h77, 32'h0);
        cycle("flush_stall");
        check_eq("flush_valid", {31'h0, w_valid}, 32'h0);
        check_eq("flush_pc", w_pc, 32'h500);
        flush = 1'b0;
        stall = 1'b0;

        reset = 1'b1; flush = 1'b1; stall = 1'b1;
        cycle("reset_prio");
        reset = 1'b0; flush = 1'b0; stall = 1'b0;

        for (int i = 0; i < 300; i++) begin
            reset = ($urandom_range(0, 39) == 0);
            flush = ($urandom_range(0, 7) == 0);
            stall = ($urandom_range(0, 3) == 0);
            randomize_instr();
            cycle("rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
